// File: rtl/isa_pkg.sv
// Shared ISA definitions for the program loader: field widths, field positions,
// opcode constants and the loader FSM state type.
package isa_pkg;

   localparam int INSTRUCTION_WIDTH = 28;
   localparam int WIDTH_OPCODE      = 5;
   localparam int REGFILE_ADDR_BITS = 5;
   localparam int IMMEDIATE_WIDTH   = 8;
   localparam int NUM_INSTRUCTIONS  = 16;
   localparam int IMEM_ADDR_BITS    = 6;

   localparam int OPCODE_LSB = 23;
   localparam int DEST_LSB   = 18;
   localparam int SOURCE_LSB = 13;

   localparam logic [WIDTH_OPCODE-1:0] INSTR_NOP = 5'd0;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_ADD = 5'd1;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_SR  = 5'd3;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_LI  = 5'd6;

   localparam logic [IMEM_ADDR_BITS-1:0] IMEM_LAST_ADDR = {IMEM_ADDR_BITS{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_WRITE  = 2'd2,
      ST_DONE   = 2'd3
   } enc_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packing of instruction fields into one word, mirroring the decoder.
// ENCODE_OPCODE_CHECK_EN: out-of-range opcodes become an all-zero NOP and flag illegal.
module instr_pack
   import isa_pkg::*;
(
   input  logic [WIDTH_OPCODE-1:0]      opcode,
   input  logic [REGFILE_ADDR_BITS-1:0] reg_dest,
   input  logic [REGFILE_ADDR_BITS-1:0] reg_source,
   input  logic [IMMEDIATE_WIDTH-1:0]   immediate,
   output logic [INSTRUCTION_WIDTH-1:0] word,
   output logic                         illegal
);

   always_comb begin
      word = '0;
      word[OPCODE_LSB +: WIDTH_OPCODE]      = opcode;
      word[DEST_LSB +: REGFILE_ADDR_BITS]   = reg_dest;
      word[SOURCE_LSB +: REGFILE_ADDR_BITS] = reg_source;
      word[0 +: IMMEDIATE_WIDTH]            = immediate;
`ifdef ENCODE_OPCODE_CHECK_EN
      illegal = (int'(opcode) >= NUM_INSTRUCTIONS);
      if (illegal) begin
         word = '0;
      end
`else
      illegal = 1'b0;
`endif
   end

endmodule

// File: rtl/encode_instruction.sv
// Program loader: accepts field sets over valid/ready, packs them and writes them
// sequentially into instruction memory. ENCODE_OPCODE_CHECK_EN enables opcode checking.
//
// state     | meaning
// ST_IDLE   | waiting for start, in_ready low
// ST_ACCEPT | in_ready high, capture packed word and address on in_valid
// ST_WRITE  | one-cycle memory write, count/pointer update
// ST_DONE   | one-cycle done pulse
module encode_instruction
   import isa_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [IMEM_ADDR_BITS-1:0]    base_addr,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH_OPCODE-1:0]      in_opcode,
   input  logic [REGFILE_ADDR_BITS-1:0] in_reg_dest,
   input  logic [REGFILE_ADDR_BITS-1:0] in_reg_source,
   input  logic [IMMEDIATE_WIDTH-1:0]   in_immediate,
   input  logic                         in_last,
   output logic                         mem_we,
   output logic [IMEM_ADDR_BITS-1:0]    mem_addr,
   output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
   output logic                         busy,
   output logic                         done,
   output logic [IMEM_ADDR_BITS:0]      count,
   output logic                         overflow,
   output logic                         error
);

   enc_state_t                    state, state_nxt;
   logic [IMEM_ADDR_BITS-1:0]     ptr;
   logic                          last_q;
   logic [INSTRUCTION_WIDTH-1:0]  packed_word;
   logic                          illegal;

   instr_pack u_pack (
      .opcode     (in_opcode),
      .reg_dest   (in_reg_dest),
      .reg_source (in_reg_source),
      .immediate  (in_immediate),
      .word       (packed_word),
      .illegal    (illegal)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_ACCEPT;
         end
         ST_ACCEPT: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            mem_we = 1'b1;
            busy   = 1'b1;
            if (last_q || (ptr == IMEM_LAST_ADDR)) state_nxt = ST_DONE;
            else                                   state_nxt = ST_ACCEPT;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The pointer saturates at the last address; overflow ends the program instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr       <= '0;
         last_q    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         error     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  ptr      <= base_addr;
                  count    <= '0;
                  overflow <= 1'b0;
                  error    <= 1'b0;
               end
            end
            ST_ACCEPT: begin
               if (in_valid) begin
                  mem_addr  <= ptr;
                  mem_wdata <= packed_word;
                  last_q    <= in_last;
                  if (illegal) error <= 1'b1;
               end
            end
            ST_WRITE: begin
               count <= count + 1'b1;
               if (!last_q) begin
                  if (ptr == IMEM_LAST_ADDR) overflow <= 1'b1;
                  else                       ptr      <= ptr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_encode_instruction.sv
// Directed self-checking bench for the program loader with hand-computed instruction words.
module tb_encode_instruction;
   import isa_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  base_addr = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_opcode = '0;
   logic [4:0]  in_reg_dest = '0;
   logic [4:0]  in_reg_source = '0;
   logic [7:0]  in_immediate = '0;
   logic        in_last = 1'b0;
   logic        mem_we;
   logic [5:0]  mem_addr;
   logic [27:0] mem_wdata;
   logic        busy;
   logic        done;
   logic [6:0]  count;
   logic        overflow;
   logic        error;

   int n_checks = 0;
   int n_fail   = 0;
   int n_writes = 0;
   int n_accepts = 0;

   encode_instruction dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .base_addr     (base_addr),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_opcode     (in_opcode),
      .in_reg_dest   (in_reg_dest),
      .in_reg_source (in_reg_source),
      .in_immediate  (in_immediate),
      .in_last       (in_last),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .busy          (busy),
      .done          (done),
      .count         (count),
      .overflow      (overflow),
      .error         (error)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge, so the rising edge sees settled handshakes and strobes.
   always @(posedge clk) begin
      if (mem_we) n_writes++;
      if (in_valid && in_ready) n_accepts++;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_prog(input logic [5:0] base);
      @(negedge clk);
      base_addr = base;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic send(input string tag, input logic [4:0] op, input logic [4:0] d,
                       input logic [4:0] s, input logic [7:0] imm, input logic last,
                       input bit keep, input logic [5:0] exp_addr, input logic [27:0] exp_word);
      bit ok;
      ok = 1'b0;
      in_opcode = op; in_reg_dest = d; in_reg_source = s; in_immediate = imm; in_last = last;
      in_valid = 1'b1;
      for (int i = 0; i < 16 && !ok; i++) begin
         if (in_ready) ok = 1'b1;
         else @(negedge clk);
      end
      check_val({tag, "_accept"}, 32'(ok), 32'd1);
      if (!ok) begin
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      if (!keep) in_valid = 1'b0;
      check_val({tag, "_we"},    32'(mem_we),    32'd1);
      check_val({tag, "_addr"},  32'(mem_addr),  32'(exp_addr));
      check_val({tag, "_wdata"}, 32'(mem_wdata), 32'(exp_word));
   endtask

   task automatic wait_done(input string tag, input logic [6:0] exp_cnt,
                            input logic exp_ovf, input logic exp_err);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         if (done) seen = 1'b1;
         else @(negedge clk);
      end
      check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
      check_val({tag, "_count"},     32'(count),    32'(exp_cnt));
      check_val({tag, "_overflow"},  32'(overflow), 32'(exp_ovf));
      check_val({tag, "_error"},     32'(error),    32'(exp_err));
      @(negedge clk);
      check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
      check_val({tag, "_idle_busy"},  32'(busy), 32'd0);
      check_val({tag, "_count_hold"}, 32'(count), 32'(exp_cnt));
   endtask

   initial begin
      int w0, a0, acc;
      logic [27:0] exp_op20;
      logic        exp_err20;

      #12;
      check_val("rst_ready", 32'(in_ready), 32'd0);
      check_val("rst_we",    32'(mem_we),   32'd0);
      check_val("rst_busy",  32'(busy),     32'd0);
      check_val("rst_count", 32'(count),    32'd0);
      @(negedge clk);
      reset = 1'b0;

      // li R5,20; li R8,22; add R8,R5 from base 0
      w0 = n_writes;
      start_prog(6'd0);
      check_val("p1_busy", 32'(busy), 32'd1);
      send("p1_w0", INSTR_LI,  5'd5, 5'd0, 8'd20, 1'b0, 1'b0, 6'd0, 28'h3140014);
      send("p1_w1", INSTR_LI,  5'd8, 5'd0, 8'd22, 1'b0, 1'b0, 6'd1, 28'h3200016);
      send("p1_w2", INSTR_ADD, 5'd8, 5'd5, 8'd0,  1'b1, 1'b0, 6'd2, 28'h0A0A000);
      @(negedge clk);
      check_val("p1_done_next_cycle", 32'(done), 32'd1);
      wait_done("p1", 7'd3, 1'b0, 1'b0);
      check_val("p1_nwrites", 32'(n_writes - w0), 32'd3);

      // in_valid held high throughout, also during WRITE cycles
      w0 = n_writes; a0 = n_accepts;
      start_prog(6'd10);
      send("bp_w0", INSTR_SR,  5'd3, 5'd2, 8'd0,   1'b0, 1'b1, 6'd10, 28'h18C4000);
      send("bp_w1", INSTR_LI,  5'd1, 5'd0, 8'h7F,  1'b0, 1'b1, 6'd11, 28'h304007F);
      send("bp_w2", INSTR_ADD, 5'd1, 5'd3, 8'd0,   1'b1, 1'b1, 6'd12, 28'h0846000);
      wait_done("bp", 7'd3, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      check_val("bp_naccepts", 32'(n_accepts - a0), 32'd3);
      check_val("bp_nwrites",  32'(n_writes - w0),  32'd3);

      // overflow at the top of memory
      w0 = n_writes; a0 = n_accepts;
      start_prog(6'd62);
      send("ov_w0", INSTR_LI, 5'd2, 5'd0, 8'd1, 1'b0, 1'b0, 6'd62, 28'h3080001);
      send("ov_w1", INSTR_LI, 5'd3, 5'd0, 8'd2, 1'b0, 1'b0, 6'd63, 28'h30C0002);
      in_opcode = INSTR_LI; in_reg_dest = 5'd4; in_immediate = 8'd3; in_last = 1'b0;
      in_valid = 1'b1;
      wait_done("ov", 7'd2, 1'b1, 1'b0);
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         if (in_ready) acc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check_val("ov_third_ready", 32'(acc), 32'd0);
      check_val("ov_naccepts", 32'(n_accepts - a0), 32'd2);
      check_val("ov_nwrites",  32'(n_writes - w0),  32'd2);

      // opcode 20 is outside the legal range
`ifdef ENCODE_OPCODE_CHECK_EN
      exp_op20 = 28'h0000000; exp_err20 = 1'b1;
`else
      exp_op20 = 28'hA000000; exp_err20 = 1'b0;
`endif
      start_prog(6'd5);
      send("op20", 5'd20, 5'd0, 5'd0, 8'd0, 1'b1, 1'b0, 6'd5, exp_op20);
      wait_done("op20", 7'd1, 1'b0, exp_err20);

      // field isolation, R0 destination kept verbatim; start clears any stale error
      start_prog(6'd7);
      send("iso", INSTR_NOP, 5'd0, 5'd31, 8'hFF, 1'b1, 1'b0, 6'd7, 28'h003E0FF);
      wait_done("iso", 7'd1, 1'b0, 1'b0);

      // asynchronous reset during the second write
      w0 = n_writes;
      start_prog(6'd20);
      send("rs_w0", INSTR_LI, 5'd5, 5'd0, 8'd20, 1'b0, 1'b0, 6'd20, 28'h3140014);
      send("rs_w1", INSTR_LI, 5'd8, 5'd0, 8'd22, 1'b0, 1'b0, 6'd21, 28'h3200016);
      #1 reset = 1'b1;
      #1;
      check_val("rs_we",    32'(mem_we),    32'd0);
      check_val("rs_addr",  32'(mem_addr),  32'd0);
      check_val("rs_wdata", 32'(mem_wdata), 32'd0);
      check_val("rs_count", 32'(count),     32'd0);
      check_val("rs_busy",  32'(busy),      32'd0);
      check_val("rs_ready", 32'(in_ready),  32'd0);
      @(negedge clk);
      reset = 1'b0;
      check_val("rs_nwrites", 32'(n_writes - w0), 32'd1);
      start_prog(6'd40);
      send("rs_new", INSTR_ADD, 5'd8, 5'd5, 8'd0, 1'b1, 1'b0, 6'd40, 28'h0A0A000);
      wait_done("rs_new", 7'd1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
